// File: rtl/sha_padder_if.sv
// Word-in / padded-block-out bus between a message source, the SHA padder and the hash core.
interface sha_padder_if;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         in_last;
    logic         in_ready;
    logic [511:0] block;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    modport master (
        output in_valid, in_data, in_nbytes, in_last, block_ready,
        input  in_ready, block, block_valid, block_last
    );

    modport slave (
        input  in_valid, in_data, in_nbytes, in_last, block_ready,
        output in_ready, block, block_valid, block_last
    );
endinterface

// File: rtl/sha_padder.sv
// SHA-1/SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks and
// appends 0x80, zero fill and the 64-bit bit length, spilling into an extra block if needed.
module sha_padder (
    input  logic        clk,
    input  logic        clr,
    sha_padder_if.slave bus
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned NWORDS  = BLOCK_W / WORD_W;
    localparam int unsigned WIDX_W  = 4;
    localparam int unsigned CNT_W   = 61;
    localparam int unsigned B_W     = 7;
    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                extra_pad_q, extra_pad_d;
    logic [BLOCK_W-1:0]  block_q, block_d;
    logic                block_valid_q, block_valid_d;
    logic                block_last_q, block_last_d;
    logic                in_ready_q, in_ready_d;

    logic [2:0]          n_eff;
    logic [WORD_W-1:0]   pad_word;
    logic [B_W-1:0]      b_total;
    logic [WIDX_W:0]     next_idx;

    // Valid bytes of the incoming word, with the 0x80 marker dropped in right after them
    always_comb begin
        n_eff = bus.in_last ? bus.in_nbytes : 3'd4;
        case (n_eff)
            3'd0:    pad_word = PAD_WORD;
            3'd1:    pad_word = {bus.in_data[31:24], 24'h80_0000};
            3'd2:    pad_word = {bus.in_data[31:16], 16'h8000};
            3'd3:    pad_word = {bus.in_data[31:8], 8'h80};
            default: pad_word = bus.in_data;
        endcase
        b_total  = B_W'({widx_q, 2'b00}) + B_W'(n_eff);
        next_idx = (WIDX_W+1)'(widx_q) + (WIDX_W+1)'(1);
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        extra_pad_d = extra_pad_q;
        block_d     = block_q;
        block_last_d = block_last_q;

        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    cnt_d = cnt_q + CNT_W'(n_eff);
                    if (!bus.in_last) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            if (WIDX_W'(i) == widx_q)
                                block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = bus.in_data;
                        end
                        if (widx_q == WIDX_W'(NWORDS-1)) begin
                            state_d      = EMIT;
                            widx_d       = '0;
                            block_last_d = 1'b0;
                        end else begin
                            widx_d = widx_q + WIDX_W'(1);
                        end
                    end else begin
                        for (int i = 0; i < NWORDS; i++) begin
                            if (WIDX_W'(i) == widx_q)
                                block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = pad_word;
                            else if ((WIDX_W+1)'(i) == next_idx && n_eff == 3'd4)
                                block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = PAD_WORD;
                            else if (WIDX_W'(i) > widx_q)
                                block_d[BLOCK_W-1-WORD_W*i -: WORD_W] = '0;
                        end
                        // Length fits only if bytes 56..63 are still free
                        if (b_total <= B_W'(55)) begin
                            block_d[63:0] = {cnt_d, 3'b000};
                            block_last_d  = 1'b1;
                        end else begin
                            pending_d    = 1'b1;
                            extra_pad_d  = (b_total == B_W'(64));
                            block_last_d = 1'b0;
                        end
                        state_d = EMIT;
                        widx_d  = '0;
                    end
                end
            end
            EMIT: begin
                if (bus.block_ready) begin
                    if (pending_q) begin
                        state_d   = EXTRA;
                        pending_d = 1'b0;
                    end else begin
                        state_d = FILL;
                        if (block_last_q) begin
                            cnt_d  = '0;
                            widx_d = '0;
                        end
                    end
                end
            end
            EXTRA: begin
                block_d = '0;
                if (extra_pad_q)
                    block_d[BLOCK_W-1 -: WORD_W] = PAD_WORD;
                block_d[63:0] = {cnt_q, 3'b000};
                extra_pad_d   = 1'b0;
                block_last_d  = 1'b1;
                state_d       = EMIT;
            end
            default: state_d = FILL;
        endcase

        block_valid_d = (state_d == EMIT);
        in_ready_d    = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= FILL;
            widx_q        <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            extra_pad_q   <= 1'b0;
            block_q       <= '0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            extra_pad_q   <= extra_pad_d;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            block_last_q  <= block_last_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign bus.block       = block_q;
    assign bus.block_valid = block_valid_q;
    assign bus.block_last  = block_last_q;
    assign bus.in_ready    = in_ready_q;
endmodule

// File: tb/tb_sha_padder.sv
// Directed bench for sha_padder: hand-checked vectors plus a byte-level SHA padding reference.
module tb_sha_padder;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    sha_padder_if bus ();
    sha_padder dut (.clk(clk), .clr(clr), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;

    logic [7:0]   msg[$];
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    logic [511:0] abc_blk;

    function automatic void build_msg(input int len);
        msg.delete();
        for (int k = 0; k < len; k++) msg.push_back(8'(k * 13 + 1));
    endfunction

    // Textbook padding on a byte stream, then cut into 64-byte blocks
    function automatic void build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        exp_q.delete();
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            exp_q.push_back(blk);
        end
    endfunction

    task automatic run_msg(input string name, input int len, input bit empty_tail, input bit stall);
        logic [31:0] wd[$];
        logic [2:0]  wn[$];
        logic [31:0] w;
        int rem;
        int nw;
        build_msg(len);
        build_expected();
        got_q.delete();
        for (int i = 0; i < len / 4; i++) begin
            wd.push_back({msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
            wn.push_back(3'd4);
        end
        rem = len % 4;
        if (rem != 0) begin
            w = 32'hA5A5_A5A5;
            for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg[4*(len/4)+j];
            wd.push_back(w);
            wn.push_back(3'(rem));
        end else if (empty_tail || len == 0) begin
            wd.push_back(32'hDEAD_BEEF);
            wn.push_back(3'd0);
        end
        nw = wd.size();
        fork
            begin
                int i;
                int cyc;
                i = 0;
                cyc = 0;
                while (i < nw && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    bus.in_valid  = 1'b1;
                    bus.in_data   = wd[i];
                    bus.in_nbytes = wn[i];
                    bus.in_last   = (i == nw - 1);
                    if (bus.in_ready) i++;
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
                if (i < nw) begin
                    checks++; failures++;
                    $display("FAIL %s send_timeout: sent %0d words, required %0d", name, i, nw);
                end
            end
            begin
                bit got;
                int cyc;
                for (int k = 0; k < exp_q.size(); k++) begin
                    got = 1'b0;
                    cyc = 0;
                    while (!got && cyc < 2000) begin
                        @(negedge clk);
                        cyc++;
                        bus.block_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
                        if (bus.block_valid && bus.block_ready) begin
                            got = 1'b1;
                            got_q.push_back(bus.block);
                            checks++;
                            if (bus.block !== exp_q[k]) begin
                                failures++;
                                $display("FAIL %s block%0d: got %h required %h", name, k, bus.block, exp_q[k]);
                            end
                            checks++;
                            if (bus.block_last !== (k == exp_q.size() - 1)) begin
                                failures++;
                                $display("FAIL %s block_last%0d: got %b required %b", name, k,
                                         bus.block_last, (k == exp_q.size() - 1));
                            end
                        end
                    end
                    if (!got) begin
                        checks++; failures++;
                        $display("FAIL %s recv_timeout: block %0d never offered", name, k);
                    end
                end
                @(negedge clk);
                bus.block_ready = 1'b0;
            end
        join
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        checks++;
        if (bus.block_valid !== 1'b0 || bus.block_last !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got valid=%b last=%b required 0 0", bus.block_valid, bus.block_last);
        end
        checks++;
        if (bus.block !== 512'd0) begin
            failures++; $display("FAIL reset_block: got %h required 0", bus.block);
        end
    endtask

    task automatic test_abc();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL abc_ready: got %b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_data = 32'h6162_63FF; bus.in_nbytes = 3'd3; bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.block_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL abc_latency: got valid=%b ready=%b required 1 0", bus.block_valid, bus.in_ready);
        end
        checks++;
        if (bus.block !== abc_blk || bus.block_last !== 1'b1) begin
            failures++; $display("FAIL abc_block: got %h last=%b required %h last=1", bus.block, bus.block_last, abc_blk);
        end
        bus.block_ready = 1'b1;
        @(negedge clk);
        bus.block_ready = 1'b0;
        checks++;
        if (bus.block_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL abc_release: got valid=%b ready=%b required 0 1", bus.block_valid, bus.in_ready);
        end
    endtask

    task automatic test_empty();
        run_msg("empty", 0, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != 1 || got_q[0][511:480] !== 32'h8000_0000 || got_q[0][479:0] !== 480'd0) begin
            failures++; $display("FAIL empty_words: got %0d blocks, required 1 with word0=80000000 rest 0", got_q.size());
        end
    endtask

    task automatic test_two_block();
        run_msg("b56", 56, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != 2 || got_q[0][63:32] !== 32'h8000_0000 || got_q[0][31:0] !== 32'd0
            || got_q[1][31:0] !== 32'h0000_01C0) begin
            failures++; $display("FAIL b56_words: got %0d blocks, required 2 with A.w14=80000000 B.w15=1c0", got_q.size());
        end
        run_msg("b64", 64, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != 2 || got_q[1][511:480] !== 32'h8000_0000 || got_q[1][31:0] !== 32'h0000_0200) begin
            failures++; $display("FAIL b64_words: got %0d blocks, required 2 with B.w0=80000000 B.w15=200", got_q.size());
        end
        run_msg("b55", 55, 1'b0, 1'b0);
        run_msg("b60", 60, 1'b0, 1'b0);
        run_msg("b52_tail", 52, 1'b1, 1'b0);
        run_msg("b64_tail", 64, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h6162_6300; bus.in_nbytes = 3'd3; bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_data = 32'h1122_3344; bus.in_nbytes = 3'd4; bus.in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.block !== abc_blk || bus.block_valid !== 1'b1 || bus.block_last !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++; $display("FAIL stall_hold%0d: got valid=%b last=%b ready=%b block=%h", c,
                                     bus.block_valid, bus.block_last, bus.in_ready, bus.block);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.block_ready = 1'b1;
        @(negedge clk);
        bus.block_ready = 1'b0;
        run_msg("after_stall", 7, 1'b0, 1'b0);
    endtask

    task automatic test_clr();
        int acc;
        acc = 0;
        for (int c = 0; c < 40 && acc < 7; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_data = 32'h0101_0101 * 32'(c + 1); bus.in_nbytes = 3'd4; bus.in_last = 1'b0;
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (bus.block_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL clr_mid: got valid=%b ready=%b required 0 1", bus.block_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_data = 32'h6162_6300; bus.in_nbytes = 3'd3; bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.block !== abc_blk || bus.block_valid !== 1'b1 || bus.block_last !== 1'b1) begin
            failures++; $display("FAIL clr_abc: got %h valid=%b required %h valid=1", bus.block, bus.block_valid, abc_blk);
        end
        // Reset wins over a simultaneous handshake
        clr = 1'b1;
        bus.block_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus.block_ready = 1'b0;
        checks++;
        if (bus.block_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.block !== 512'd0) begin
            failures++; $display("FAIL clr_emit: got valid=%b ready=%b block=%h required 0 1 0",
                                 bus.block_valid, bus.in_ready, bus.block);
        end
    endtask

    task automatic test_back_to_back();
        run_msg("b2b_3", 3, 1'b0, 1'b1);
        run_msg("b2b_130", 130, 1'b0, 1'b1);
        run_msg("b2b_0", 0, 1'b0, 1'b1);
        run_msg("b2b_120", 120, 1'b1, 1'b1);
    endtask

    initial begin
        clr = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_nbytes = '0; bus.in_last = 1'b0;
        bus.block_ready = 1'b0;
        abc_blk = '0;
        abc_blk[511:480] = 32'h6162_6380;
        abc_blk[31:0]    = 32'h0000_0018;
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_stall();
        test_clr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
